axi_txn_limiter: RTL and testbench

- AXI4 full-channel stage between the core's memory master port and the address-remapping stage ahead of the PS memory slave port.
- Bounds the number of outstanding read and write transactions so the interconnect cannot be flooded.
- Provides a drain handshake so software or the reset controller can quiesce the memory path before a core reset.
- Payload passes through combinationally; only valid/ready on AW/AR are gated. Adds no latency.

---
 rtl/axi_txn_limiter_pkg.sv | 15 +
 rtl/axi_txn_limiter_txn_counter.sv | 42 ++++
 rtl/axi_txn_limiter.sv | 182 ++++++++++++++++++
 tb/tb_axi_txn_limiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_txn_limiter_pkg.sv
// Shared definitions for the AXI outstanding-transaction limiter.
package axi_txn_limiter_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  function automatic int cnt_w(input int max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/axi_txn_limiter_txn_counter.sv
// Up/down outstanding-burst counter that saturates at MAX and clamps at zero.
module txn_counter
  import axi_txn_limiter_pkg::*;
#(
  parameter int MAX = 4,
  parameter int W   = cnt_w(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic [W-1:0] cnt_next,
  output logic         full,
  output logic         underflow
);

  logic zero;

  assign full = (cnt == W'(MAX));
  assign zero = (cnt == '0);

  always_comb begin
    cnt_next  = cnt;
    // A response with nothing outstanding cannot belong to any accepted request.
    underflow = dec & zero;
    if (inc & ~dec & ~full) begin
      cnt_next = cnt + W'(1);
    end else if (dec & ~inc & ~zero) begin
      cnt_next = cnt - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/axi_txn_limiter.sv
// AXI4 pass-through that caps outstanding reads/writes and offers a drain handshake.
// Optional stall counters are enabled with `define AXI_TXN_LIMITER_STATS_EN.
module axi_txn_limiter
  import axi_txn_limiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 1,
  parameter int MAX_RD = 4,
  parameter int MAX_WR = 4
) (
  input  logic                uncoreclk,
  input  logic                uncorerst,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [ID_W-1:0]     s_axi_awid,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic [1:0]          s_axi_awburst,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  output logic [1:0]          s_axi_bresp,
  output logic [ID_W-1:0]     s_axi_bid,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic [ID_W-1:0]     s_axi_arid,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic [1:0]          s_axi_arburst,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic [ID_W-1:0]     s_axi_rid,
  output logic                s_axi_rlast,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [ID_W-1:0]     m_axi_awid,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  input  logic [1:0]          m_axi_bresp,
  input  logic [ID_W-1:0]     m_axi_bid,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [ID_W-1:0]     m_axi_arid,
  output logic [7:0]          m_axi_arlen,
  output logic [2:0]          m_axi_arsize,
  output logic [1:0]          m_axi_arburst,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic [ID_W-1:0]     m_axi_rid,
  input  logic                m_axi_rlast,
  input  logic                drain_req,
  output logic                drain_ack,
  output logic                err
`ifdef AXI_TXN_LIMITER_STATS_EN
  ,
  output logic [31:0]         aw_stall_cnt,
  output logic [31:0]         ar_stall_cnt
`endif
);

  localparam int RD_W = cnt_w(MAX_RD);
  localparam int WR_W = cnt_w(MAX_WR);

  logic [RD_W-1:0] rd_cnt, rd_cnt_next;
  logic [WR_W-1:0] wr_cnt, wr_cnt_next;
  logic            rd_full, wr_full, rd_uf, wr_uf;
  logic            aw_block, ar_block;
  logic            aw_hs, ar_hs, b_hs, r_last_hs;

  // Blocking looks only at registered counts, so awvalid never reaches awready.
  assign aw_block = drain_req | wr_full;
  assign ar_block = drain_req | rd_full;

  assign m_axi_awvalid = s_axi_awvalid & ~aw_block;
  assign s_axi_awready = m_axi_awready & ~aw_block;
  assign m_axi_arvalid = s_axi_arvalid & ~ar_block;
  assign s_axi_arready = m_axi_arready & ~ar_block;

  assign m_axi_awaddr  = s_axi_awaddr;
  assign m_axi_awid    = s_axi_awid;
  assign m_axi_awlen   = s_axi_awlen;
  assign m_axi_awsize  = s_axi_awsize;
  assign m_axi_awburst = s_axi_awburst;
  assign m_axi_araddr  = s_axi_araddr;
  assign m_axi_arid    = s_axi_arid;
  assign m_axi_arlen   = s_axi_arlen;
  assign m_axi_arsize  = s_axi_arsize;
  assign m_axi_arburst = s_axi_arburst;

  assign m_axi_wvalid  = s_axi_wvalid;
  assign s_axi_wready  = m_axi_wready;
  assign m_axi_wdata   = s_axi_wdata;
  assign m_axi_wstrb   = s_axi_wstrb;
  assign m_axi_wlast   = s_axi_wlast;

  assign s_axi_bvalid  = m_axi_bvalid;
  assign m_axi_bready  = s_axi_bready;
  assign s_axi_bresp   = m_axi_bresp;
  assign s_axi_bid     = m_axi_bid;

  assign s_axi_rvalid  = m_axi_rvalid;
  assign m_axi_rready  = s_axi_rready;
  assign s_axi_rdata   = m_axi_rdata;
  assign s_axi_rresp   = m_axi_rresp;
  assign s_axi_rid     = m_axi_rid;
  assign s_axi_rlast   = m_axi_rlast;

  assign aw_hs     = s_axi_awvalid & s_axi_awready;
  assign ar_hs     = s_axi_arvalid & s_axi_arready;
  assign b_hs      = m_axi_bvalid & s_axi_bready;
  assign r_last_hs = m_axi_rvalid & s_axi_rready & m_axi_rlast;

  txn_counter #(.MAX(MAX_WR), .W(WR_W)) u_wr (
    .clk       (uncoreclk),
    .rst       (uncorerst),
    .inc       (aw_hs),
    .dec       (b_hs),
    .cnt       (wr_cnt),
    .cnt_next  (wr_cnt_next),
    .full      (wr_full),
    .underflow (wr_uf)
  );

  txn_counter #(.MAX(MAX_RD), .W(RD_W)) u_rd (
    .clk       (uncoreclk),
    .rst       (uncorerst),
    .inc       (ar_hs),
    .dec       (r_last_hs),
    .cnt       (rd_cnt),
    .cnt_next  (rd_cnt_next),
    .full      (rd_full),
    .underflow (rd_uf)
  );

  always_ff @(posedge uncoreclk) begin
    if (uncorerst) begin
      err       <= 1'b0;
      drain_ack <= 1'b0;
    end else begin
      err       <= err | wr_uf | rd_uf;
      drain_ack <= drain_req & (rd_cnt_next == '0) & (wr_cnt_next == '0);
    end
  end

`ifdef AXI_TXN_LIMITER_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge uncoreclk) begin
    if (uncorerst) begin
      aw_stall_cnt <= '0;
      ar_stall_cnt <= '0;
    end else begin
      if (s_axi_awvalid & aw_block) aw_stall_cnt <= sat_inc(aw_stall_cnt);
      if (s_axi_arvalid & ar_block) ar_stall_cnt <= sat_inc(ar_stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_axi_txn_limiter.sv
// Directed bench for axi_txn_limiter with MAX_RD = MAX_WR = 4.
module tb_axi_txn_limiter;

  logic        uncoreclk = 1'b0;
  logic        uncorerst;
  logic        s_axi_awvalid, s_axi_awready;
  logic [31:0] s_axi_awaddr;
  logic [0:0]  s_axi_awid;
  logic [7:0]  s_axi_awlen;
  logic [2:0]  s_axi_awsize;
  logic [1:0]  s_axi_awburst;
  logic        s_axi_wvalid, s_axi_wready;
  logic [63:0] s_axi_wdata;
  logic [7:0]  s_axi_wstrb;
  logic        s_axi_wlast;
  logic        s_axi_bvalid, s_axi_bready;
  logic [1:0]  s_axi_bresp;
  logic [0:0]  s_axi_bid;
  logic        s_axi_arvalid, s_axi_arready;
  logic [31:0] s_axi_araddr;
  logic [0:0]  s_axi_arid;
  logic [7:0]  s_axi_arlen;
  logic [2:0]  s_axi_arsize;
  logic [1:0]  s_axi_arburst;
  logic        s_axi_rvalid, s_axi_rready;
  logic [63:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic [0:0]  s_axi_rid;
  logic        s_axi_rlast;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_awaddr;
  logic [0:0]  m_axi_awid;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_wvalid, m_axi_wready;
  logic [63:0] m_axi_wdata;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_bvalid, m_axi_bready;
  logic [1:0]  m_axi_bresp;
  logic [0:0]  m_axi_bid;
  logic        m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_araddr;
  logic [0:0]  m_axi_arid;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_rvalid, m_axi_rready;
  logic [63:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic [0:0]  m_axi_rid;
  logic        m_axi_rlast;
  logic        drain_req, drain_ack, err;
`ifdef AXI_TXN_LIMITER_STATS_EN
  logic [31:0] aw_stall_cnt, ar_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 uncoreclk = ~uncoreclk;

  axi_txn_limiter #(
    .ADDR_W(32), .DATA_W(64), .ID_W(1), .MAX_RD(4), .MAX_WR(4)
  ) dut (
    .uncoreclk(uncoreclk), .uncorerst(uncorerst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_awid(s_axi_awid), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp), .s_axi_bid(s_axi_bid),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
    .s_axi_arid(s_axi_arid), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp), .s_axi_rid(s_axi_rid), .s_axi_rlast(s_axi_rlast),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awid(m_axi_awid), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp), .m_axi_bid(m_axi_bid),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arid(m_axi_arid), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rid(m_axi_rid), .m_axi_rlast(m_axi_rlast),
    .drain_req(drain_req), .drain_ack(drain_ack), .err(err)
`ifdef AXI_TXN_LIMITER_STATS_EN
    , .aw_stall_cnt(aw_stall_cnt), .ar_stall_cnt(ar_stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and registered outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge uncoreclk);
    #1;
  endtask

  initial begin
    uncorerst = 1'b1; drain_req = 1'b0;
    s_axi_awvalid = 0; s_axi_awaddr = '0; s_axi_awid = '0; s_axi_awlen = '0; s_axi_awsize = 3'd3; s_axi_awburst = 2'b01;
    s_axi_wvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 0; s_axi_bready = 1'b1;
    s_axi_arvalid = 0; s_axi_araddr = '0; s_axi_arid = '0; s_axi_arlen = '0; s_axi_arsize = 3'd3; s_axi_arburst = 2'b01;
    s_axi_rready = 1'b1;
    m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bvalid = 0; m_axi_bresp = '0; m_axi_bid = '0;
    m_axi_arready = 1'b1; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rid = '0; m_axi_rlast = 0;
    tick(); tick();
    uncorerst = 1'b0;
    chk("rst_wr_cnt", 64'(dut.wr_cnt), 0);
    chk("rst_rd_cnt", 64'(dut.rd_cnt), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_drain_ack", 64'(drain_ack), 0);

    // Five back-to-back AWs against a write limit of four
    s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h8000_0100;
    for (int i = 0; i < 4; i++) begin
      #1 chk("aw_ready_open", 64'(s_axi_awready), 1);
      tick();
    end
    chk("aw_cnt_full", 64'(dut.wr_cnt), 4);
    chk("aw5_m_valid", 64'(m_axi_awvalid), 0);
    chk("aw5_s_ready", 64'(s_axi_awready), 0);
    chk("aw_addr_pass", 64'(m_axi_awaddr), 64'h8000_0100);
    s_axi_wvalid = 1'b1; s_axi_wdata = 64'h0123_4567_89AB_CDEF; s_axi_wstrb = 8'hF0;
    #1 chk("w_data_pass", m_axi_wdata, 64'h0123_4567_89AB_CDEF);
    chk("w_valid_ungated", 64'(m_axi_wvalid), 1);
    s_axi_wvalid = 1'b0;
    m_axi_bvalid = 1'b1; m_axi_bresp = 2'b10; m_axi_bid = 1'b1;
    #1 chk("b_resp_pass", 64'(s_axi_bresp), 2);
    tick();
    m_axi_bvalid = 1'b0;
    chk("b_dec_cnt", 64'(dut.wr_cnt), 3);
    chk("aw5_unblocked", 64'(s_axi_awready), 1);
    tick();
    s_axi_awvalid = 1'b0;
    chk("aw5_accepted", 64'(dut.wr_cnt), 4);

    // Reads: fill, then simultaneous AR + last beat, then non-last beat
    s_axi_arvalid = 1'b1;
    repeat (4) tick();
    s_axi_arvalid = 1'b0;
    chk("ar_cnt_full", 64'(dut.rd_cnt), 4);
    chk("ar_blocked", 64'(s_axi_arready), 0);
    m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1; m_axi_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    #1 chk("r_data_pass", s_axi_rdata, 64'hDEAD_BEEF_CAFE_F00D);
    tick();
    chk("r_last_dec", 64'(dut.rd_cnt), 3);
    s_axi_arvalid = 1'b1;
    tick();
    chk("ar_and_rlast_same", 64'(dut.rd_cnt), 3);
    m_axi_rvalid = 1'b0;
    tick();
    s_axi_arvalid = 1'b0;
    chk("ar_refill", 64'(dut.rd_cnt), 4);
    m_axi_rvalid = 1'b1; m_axi_rlast = 1'b0;
    tick();
    chk("r_nonlast_hold", 64'(dut.rd_cnt), 4);
    m_axi_rlast = 1'b1;
    repeat (4) tick();
    m_axi_rvalid = 1'b0;
    chk("r_drained", 64'(dut.rd_cnt), 0);
    m_axi_bvalid = 1'b1;
    repeat (4) tick();
    m_axi_bvalid = 1'b0;
    chk("b_drained", 64'(dut.wr_cnt), 0);
    chk("no_err_yet", 64'(err), 0);

    // Drain while idle
    drain_req = 1'b1;
    tick();
    chk("drain_idle_ack", 64'(drain_ack), 1);
    drain_req = 1'b0;
    tick();
    chk("drain_idle_drop", 64'(drain_ack), 0);

    // Drain with one write and two reads outstanding
    s_axi_awvalid = 1'b1; s_axi_arvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    tick();
    s_axi_arvalid = 1'b0;
    chk("drain_setup_wr", 64'(dut.wr_cnt), 1);
    chk("drain_setup_rd", 64'(dut.rd_cnt), 2);
    drain_req = 1'b1; s_axi_awvalid = 1'b1; s_axi_arvalid = 1'b1;
    #1 chk("drain_aw_ready", 64'(s_axi_awready), 0);
    chk("drain_m_awvalid", 64'(m_axi_awvalid), 0);
    chk("drain_ar_ready", 64'(s_axi_arready), 0);
    chk("drain_m_arvalid", 64'(m_axi_arvalid), 0);
    tick();
    s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
    chk("drain_busy_ack", 64'(drain_ack), 0);
    chk("drain_no_new_rd", 64'(dut.rd_cnt), 2);
    m_axi_bvalid = 1'b1;
    tick();
    m_axi_bvalid = 1'b0;
    chk("drain_b_ack", 64'(drain_ack), 0);
    m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1;
    tick();
    chk("drain_r1_ack", 64'(drain_ack), 0);
    tick();
    m_axi_rvalid = 1'b0;
    chk("drain_final_ack", 64'(drain_ack), 1);
    drain_req = 1'b0;
    tick();
    chk("drain_release", 64'(drain_ack), 0);

    // Underflow on B sets sticky err
    m_axi_bvalid = 1'b1;
    tick();
    m_axi_bvalid = 1'b0;
    chk("uf_err_set", 64'(err), 1);
    chk("uf_wr_zero", 64'(dut.wr_cnt), 0);
    repeat (100) tick();
    chk("uf_err_sticky", 64'(err), 1);
    uncorerst = 1'b1;
    tick();
    uncorerst = 1'b0;
    chk("uf_err_cleared", 64'(err), 0);
    m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1;
    tick();
    m_axi_rvalid = 1'b0;
    chk("uf_r_err", 64'(err), 1);
    chk("uf_rd_zero", 64'(dut.rd_cnt), 0);

    // Reset with reads in flight
    uncorerst = 1'b1;
    tick();
    uncorerst = 1'b0;
    s_axi_arvalid = 1'b1;
    repeat (3) tick();
    s_axi_arvalid = 1'b0;
    chk("pre_rst_rd", 64'(dut.rd_cnt), 3);
    drain_req = 1'b1; uncorerst = 1'b1;
    tick();
    uncorerst = 1'b0; drain_req = 1'b0;
    chk("rst_flight_rd", 64'(dut.rd_cnt), 0);
    chk("rst_flight_ack", 64'(drain_ack), 0);
    s_axi_arvalid = 1'b1;
    repeat (4) tick();
    chk("post_rst_rd", 64'(dut.rd_cnt), 4);
    chk("post_rst_block", 64'(m_axi_arvalid), 0);

`ifdef AXI_TXN_LIMITER_STATS_EN
    repeat (10) tick();
    chk("ar_stall_10", 64'(ar_stall_cnt), 10);
    chk("aw_stall_0", 64'(aw_stall_cnt), 0);
    s_axi_arvalid = 1'b0;
    force dut.ar_stall_cnt = 32'hFFFF_FFFE;
    #1 release dut.ar_stall_cnt;
    s_axi_arvalid = 1'b1;
    repeat (3) tick();
    chk("ar_stall_sat", 64'(ar_stall_cnt), 64'hFFFF_FFFF);
`endif
    s_axi_arvalid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
